planificador_movimiento: RTL and testbench
==========================================

# planificador_movimiento

Sequential, parametrised direction planner for the elevator controller. It latches floor requests, decides motor enable and direction with a SCAN policy (keep the current direction while requests remain ahead), and times the door dwell at each served floor. It sits between the request inputs and floor sensor on one side and the motor driver and door actuator on the other.

## Interface
- N_PISOS, 5, number of floors (≥2); floor 0 is the lowest.
- ANCHO_PISO, $clog2(N_PISOS), width of the floor code.
- T_PUERTA, 16, door dwell in clock cycles (≥1).
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- piso_actual  in  ANCHO_PISO  current floor code from the position sensor.
- en_piso  in  1  cabin is level with `piso_actual`.
- solicitud  in  N_PISOS  request pulses or levels; bit i requests floor i.
- accion  out  2  {motor_on, dir}; dir is 0 for up and 1 for down. Values: 00 stop, 10 up, 11 down.
- puerta_abierta  out  1  door-open command.
- pendientes  out  N_PISOS  registered pending-request vector.
- error_piso  out  1  sticky flag for an out-of-range floor code.

## Operation
- Pending register: `pend <= (pend | solicitud) & ~limpiar`. `limpiar` is one-hot at the current floor on entry to PUERTA.
- A request for the current floor while in PUERTA reloads the dwell timer. That bit stays clear.
- Combinational helpers: `arriba` = any pend bit above the floor; `abajo` = any pend bit below the floor; `aqui` = pend[floor].
- `dir_mem` holds the last travel direction. Reset value is up.
- States: REPOSO, SUBIENDO, BAJANDO, PUERTA. `accion` and `puerta_abierta` are Moore-decoded from the state register.
- REPOSO (accion 00):
  - `aqui & en_piso` goes to PUERTA.
  - Otherwise, if `arriba` and `abajo` are both set, follow `dir_mem`.
  - Otherwise `arriba` goes to SUBIENDO and `abajo` goes to BAJANDO.
- SUBIENDO (10):
  - `en_piso & aqui` goes to PUERTA.
  - `en_piso & ~arriba` goes to REPOSO.
  - At floor N_PISOS-1 it never continues upward; it goes to PUERTA if `aqui`, else REPOSO.
- BAJANDO (11): mirror image of SUBIENDO, with floor 0 as the limit.
- PUERTA (00, puerta_abierta 1):
  - Timer loads T_PUERTA-1 on entry and decrements each cycle.
  - At 0: continue in `dir_mem` if requests remain ahead, else reverse if requests remain behind, else REPOSO.
- Entering SUBIENDO or BAJANDO updates `dir_mem`.
- Out-of-range floor code (decoded ≥ N_PISOS):
  - sets `error_piso`;
  - forces REPOSO with accion 00;
  - freezes departures until reset.
  - `pend` keeps accepting requests.

## Timing
- Reset values: state REPOSO, pend 0, `dir_mem` up, timer 0, accion 00, puerta_abierta 0, error_piso 0.
- Request at edge k is visible in `pendientes` after edge k. Earliest `accion` change is after edge k+1.
- Arrival: `en_piso` with `aqui` sampled at edge k gives accion 00 and puerta_abierta 1 after edge k+1.
- Door is open for exactly T_PUERTA cycles unless reloaded.
- Simultaneous request and clear of the same bit: clear wins, and the timer reloads.
- Reset mid-travel drops the motor immediately (asynchronous) and discards all pending requests.
- Timer width is $clog2(T_PUERTA+1). Floor comparisons are unsigned at ANCHO_PISO width.

## Configuration
- PISO_GRAY_EN defined: `piso_actual` is Gray-coded and is converted to binary before any comparison. The conversion is combinational, so no extra latency.
- PISO_GRAY_EN undefined: `piso_actual` is plain binary and no decoder is instantiated.

## Structure
- Shared package holds:
  - state encoding: REPOSO, SUBIENDO, BAJANDO, PUERTA;
  - `accion` constants: ACC_PARAR=2'b00, ACC_SUBIR=2'b10, ACC_BAJAR=2'b11;
  - DIR_SUBIR=0, DIR_BAJAR=1.
- One sub-module, `gray_a_binario`, parametrised by width and instantiated only under PISO_GRAY_EN.

## Test plan
All scenarios use N_PISOS=5 and T_PUERTA=4.
- Reset at floor 0 with no requests → accion 00, pendientes 00000, puerta_abierta 0, held indefinitely.
- At floor 0, solicitud[3] pulsed → accion 10. Walk en_piso through floors 1 and 2: no stop. At floor 3, accion 00, puerta_abierta high for 4 cycles, pendientes 00000, then REPOSO.
- At floor 2 moving up with pend 00001 | 10000 → continues to floor 4, opens the door, then goes down (accion 11) to floor 0.
- At floor 2 idle, solicitud 00010 and 01000 in the same cycle, `dir_mem` down → accion 11 first.
- Door open at floor 1, solicitud[1] pulsed on the 3rd dwell cycle → dwell extends to 4 cycles from the pulse, and pend[1] stays 0.
- piso_actual=3'b110 while moving → error_piso 1, accion 00 on the next cycle. It stays stopped and keeps latching requests until rst_n asserts.

Source files
------------

// File: rtl/planificador_movimiento_pkg.sv
// -----------------------------------------------------------------------------
// planificador_movimiento_pkg
// Shared definitions for the elevator direction planner: FSM state encoding,
// motor command constants ({motor_on, dir}) and travel direction constants.
// -----------------------------------------------------------------------------
package planificador_movimiento_pkg;

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        SUBIENDO = 2'd1,
        BAJANDO  = 2'd2,
        PUERTA   = 2'd3
    } estado_t;

    localparam logic [1:0] ACC_PARAR = 2'b00;
    localparam logic [1:0] ACC_SUBIR = 2'b10;
    localparam logic [1:0] ACC_BAJAR = 2'b11;

    localparam logic DIR_SUBIR = 1'b0;
    localparam logic DIR_BAJAR = 1'b1;

    // Moore decode of the motor command for a given state
    function automatic logic [1:0] accion_de(input estado_t e);
        logic [1:0] a;
        case (e)
            SUBIENDO: a = ACC_SUBIR;
            BAJANDO:  a = ACC_BAJAR;
            default:  a = ACC_PARAR;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/planificador_movimiento_gray_a_binario.sv
// -----------------------------------------------------------------------------
// gray_a_binario
// Purely combinational Gray-to-binary converter.
// Ports:
//   gray    in  ANCHO  Gray-coded value
//   binario out ANCHO  binary equivalent
// -----------------------------------------------------------------------------
module gray_a_binario #(
    parameter int ANCHO = 3
) (
    input  logic [ANCHO-1:0] gray,
    output logic [ANCHO-1:0] binario
);

    always_comb begin
        binario            = '0;
        binario[ANCHO-1]   = gray[ANCHO-1];
        for (int unsigned i = 1; i < ANCHO; i++) begin
            binario[ANCHO-1-i] = binario[ANCHO-i] ^ gray[ANCHO-1-i];
        end
    end

endmodule

// File: rtl/planificador_movimiento.sv
// -----------------------------------------------------------------------------
// planificador_movimiento
// SCAN direction planner for the elevator controller. Latches floor requests,
// chooses motor enable/direction (keep direction while requests remain ahead)
// and times the door dwell at each served floor.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   piso_actual    in   floor code from the position sensor
//   en_piso        in   cabin level with piso_actual
//   solicitud      in   request vector, bit i requests floor i
//   accion         out  {motor_on, dir}: 00 stop, 10 up, 11 down
//   puerta_abierta out  door-open command
//   pendientes     out  registered pending-request vector
//   error_piso     out  sticky out-of-range floor code flag
//
// Build option: define PISO_GRAY_EN when piso_actual is Gray coded; it is
// then converted to binary combinationally before any comparison.
//
// The floor sensor (decoded floor, en_piso) is registered once, so an arrival
// sampled at edge k moves the FSM at edge k+1, the same spacing a new request
// has between pendientes and accion.
// -----------------------------------------------------------------------------
module planificador_movimiento
    import planificador_movimiento_pkg::*;
#(
    parameter int N_PISOS    = 5,
    parameter int ANCHO_PISO = $clog2(N_PISOS),
    parameter int T_PUERTA   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ANCHO_PISO-1:0] piso_actual,
    input  logic                  en_piso,
    input  logic [N_PISOS-1:0]    solicitud,
    output logic [1:0]            accion,
    output logic                  puerta_abierta,
    output logic [N_PISOS-1:0]    pendientes,
    output logic                  error_piso
);

    localparam int                  TW     = $clog2(T_PUERTA + 1);
    localparam logic [TW-1:0]       CARGA  = TW'(T_PUERTA - 1);
    localparam logic [ANCHO_PISO-1:0] TOPE = ANCHO_PISO'(N_PISOS - 1);
    localparam logic [ANCHO_PISO:0] LIMITE = (ANCHO_PISO + 1)'(N_PISOS);

    logic [ANCHO_PISO-1:0] piso_bin;
    logic [ANCHO_PISO-1:0] piso_r;
    logic                  en_r;
    logic                  fuera;

    estado_t               estado, est_sig;
    logic [N_PISOS-1:0]    pend, limpiar, unos_piso;
    logic [TW-1:0]         timer, tmr_sig;
    logic                  dir_mem, dir_sig;
    logic                  arriba, abajo, aqui, sol_aqui;
    logic                  en_tope, en_fondo;

`ifdef PISO_GRAY_EN
    gray_a_binario #(.ANCHO(ANCHO_PISO)) u_gray_a_binario (
        .gray    (piso_actual),
        .binario (piso_bin)
    );
`else
    assign piso_bin = piso_actual;
`endif

    assign fuera      = {1'b0, piso_bin} >= LIMITE;
    assign pendientes = pend;
    assign en_tope    = (piso_r == TOPE);
    assign en_fondo   = (piso_r == '0);

    // Floor-relative views of the pending vector; an out-of-range floor
    // matches no bit, so aqui/sol_aqui stay low there.
    always_comb begin
        arriba    = 1'b0;
        abajo     = 1'b0;
        aqui      = 1'b0;
        sol_aqui  = 1'b0;
        unos_piso = '0;
        for (int unsigned i = 0; i < N_PISOS; i++) begin
            if (ANCHO_PISO'(i) > piso_r) arriba = arriba | pend[i];
            if (ANCHO_PISO'(i) < piso_r) abajo  = abajo  | pend[i];
            if (ANCHO_PISO'(i) == piso_r) begin
                aqui         = pend[i];
                sol_aqui     = solicitud[i];
                unos_piso[i] = 1'b1;
            end
        end
    end

    always_comb begin
        est_sig = estado;
        tmr_sig = timer;
        dir_sig = dir_mem;
        if (error_piso) begin
            est_sig = REPOSO;
        end else begin
            case (estado)
                REPOSO: begin
                    if (aqui && en_r)             est_sig = PUERTA;
                    else if (arriba && abajo)     est_sig = (dir_mem == DIR_SUBIR) ? SUBIENDO : BAJANDO;
                    else if (arriba)              est_sig = SUBIENDO;
                    else if (abajo)               est_sig = BAJANDO;
                end
                SUBIENDO: begin
                    if ((en_r || en_tope) && aqui)          est_sig = PUERTA;
                    else if ((en_r && !arriba) || en_tope)  est_sig = REPOSO;
                end
                BAJANDO: begin
                    if ((en_r || en_fondo) && aqui)         est_sig = PUERTA;
                    else if ((en_r && !abajo) || en_fondo)  est_sig = REPOSO;
                end
                PUERTA: begin
                    if (sol_aqui) begin
                        tmr_sig = CARGA;
                    end else if (timer == '0) begin
                        if (dir_mem == DIR_SUBIR)
                            est_sig = arriba ? SUBIENDO : (abajo ? BAJANDO : REPOSO);
                        else
                            est_sig = abajo ? BAJANDO : (arriba ? SUBIENDO : REPOSO);
                    end else begin
                        tmr_sig = timer - TW'(1);
                    end
                end
                default: est_sig = REPOSO;
            endcase
        end
        if (est_sig == PUERTA && estado != PUERTA) tmr_sig = CARGA;
        if (est_sig == SUBIENDO) dir_sig = DIR_SUBIR;
        if (est_sig == BAJANDO)  dir_sig = DIR_BAJAR;
    end

    // Current floor stays cleared for the whole stay in PUERTA, so a repeat
    // request there only reloads the dwell timer.
    assign limpiar = (est_sig == PUERTA) ? unos_piso : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado         <= REPOSO;
            timer          <= '0;
            dir_mem        <= DIR_SUBIR;
            pend           <= '0;
            piso_r         <= '0;
            en_r           <= 1'b0;
            accion         <= ACC_PARAR;
            puerta_abierta <= 1'b0;
            error_piso     <= 1'b0;
        end else begin
            estado         <= est_sig;
            timer          <= tmr_sig;
            dir_mem        <= dir_sig;
            pend           <= (pend | solicitud) & ~limpiar;
            piso_r         <= piso_bin;
            en_r           <= en_piso;
            accion         <= accion_de(est_sig);
            puerta_abierta <= (est_sig == PUERTA);
            error_piso     <= error_piso | fuera;
        end
    end

endmodule

// File: tb/tb_planificador_movimiento.sv
module tb_planificador_movimiento;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] piso_actual = 3'd0;
    logic       en_piso = 1'b1;
    logic [4:0] solicitud = 5'b00000;
    logic [1:0] accion;
    logic       puerta_abierta;
    logic [4:0] pendientes;
    logic       error_piso;

    int n_cmp  = 0;
    int n_fail = 0;

    planificador_movimiento #(
        .N_PISOS  (5),
        .T_PUERTA (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .piso_actual    (piso_actual),
        .en_piso        (en_piso),
        .solicitud      (solicitud),
        .accion         (accion),
        .puerta_abierta (puerta_abierta),
        .pendientes     (pendientes),
        .error_piso     (error_piso)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic ir_a(input logic [2:0] p);
        piso_actual = p;
        en_piso     = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        // ---- reset at floor 0, idle ----
        #2 rst_n = 1'b0;
        #1;
        check("rst_accion", 8'(accion), 8'b00);
        check("rst_pend", 8'(pendientes), 8'b00000);
        check("rst_puerta", 8'(puerta_abierta), 8'd0);
        check("rst_error", 8'(error_piso), 8'd0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_accion", 8'(accion), 8'b00);
        check("idle_pend", 8'(pendientes), 8'b00000);

        // ---- floor 0 -> floor 3, pass 1 and 2 ----
        solicitud = 5'b01000;
        tick();
        solicitud = 5'b00000;
        check("s2_pend", 8'(pendientes), 8'b01000);
        check("s2_acc_pre", 8'(accion), 8'b00);
        tick();
        check("s2_sube", 8'(accion), 8'b10);
        ir_a(3'd1);
        check("s2_piso1", 8'(accion), 8'b10);
        ir_a(3'd2);
        check("s2_piso2", 8'(accion), 8'b10);
        ir_a(3'd3);
        check("s2_llega_acc", 8'(accion), 8'b00);
        check("s2_llega_pta", 8'(puerta_abierta), 8'd1);
        check("s2_llega_pend", 8'(pendientes), 8'b00000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s2_dwell", 8'(puerta_abierta), 8'd1);
        end
        tick();
        check("s2_cierra", 8'(puerta_abierta), 8'd0);
        check("s2_reposo", 8'(accion), 8'b00);

        // ---- up past 2 to 4, then down to 0 ----
        rst_n = 1'b0;
        piso_actual = 3'd1;
        tick();
        rst_n = 1'b1;
        tick();
        solicitud = 5'b10001;
        tick();
        solicitud = 5'b00000;
        tick();
        check("s3_sube", 8'(accion), 8'b10);
        check("s3_pend", 8'(pendientes), 8'b10001);
        ir_a(3'd2);
        check("s3_piso2", 8'(accion), 8'b10);
        ir_a(3'd3);
        check("s3_piso3", 8'(accion), 8'b10);
        ir_a(3'd4);
        check("s3_tope_acc", 8'(accion), 8'b00);
        check("s3_tope_pta", 8'(puerta_abierta), 8'd1);
        check("s3_tope_pend", 8'(pendientes), 8'b00001);
        repeat (3) tick();
        tick();
        check("s3_baja", 8'(accion), 8'b11);
        check("s3_baja_pta", 8'(puerta_abierta), 8'd0);
        for (int p = 3; p >= 1; p--) begin
            ir_a(3'(p));
            check("s3_bajando", 8'(accion), 8'b11);
        end
        ir_a(3'd0);
        check("s3_fondo_acc", 8'(accion), 8'b00);
        check("s3_fondo_pta", 8'(puerta_abierta), 8'd1);
        check("s3_fondo_pend", 8'(pendientes), 8'b00000);
        repeat (4) tick();
        check("s3_reposo", 8'(puerta_abierta), 8'd0);

        // ---- floor 2 idle, requests both sides, last dir down ----
        ir_a(3'd2);
        solicitud = 5'b01010;
        tick();
        solicitud = 5'b00000;
        tick();
        check("s4_baja_primero", 8'(accion), 8'b11);

        // ---- door at floor 1, repeat request on 3rd dwell cycle ----
        ir_a(3'd1);
        check("s5_llega_pta", 8'(puerta_abierta), 8'd1);
        check("s5_llega_pend", 8'(pendientes), 8'b01000);
        tick();
        tick();
        solicitud = 5'b00010;
        tick();
        solicitud = 5'b00000;
        check("s5_pend_limpio", 8'(pendientes), 8'b01000);
        check("s5_recarga", 8'(puerta_abierta), 8'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s5_dwell_ext", 8'(puerta_abierta), 8'd1);
        end
        tick();
        check("s5_cierra", 8'(puerta_abierta), 8'd0);
        check("s5_invierte", 8'(accion), 8'b10);

        // ---- out-of-range code while moving ----
        piso_actual = 3'b110;
        en_piso = 1'b0;
        tick();
        check("s6_error", 8'(error_piso), 8'd1);
        tick();
        check("s6_para", 8'(accion), 8'b00);
        solicitud = 5'b00001;
        tick();
        solicitud = 5'b00000;
        check("s6_latch", 8'(pendientes), 8'b01001);
        ir_a(3'd1);
        repeat (3) tick();
        check("s6_congelado", 8'(accion), 8'b00);
        check("s6_sticky", 8'(error_piso), 8'd1);
        rst_n = 1'b0;
        #1;
        check("s6_rst_error", 8'(error_piso), 8'd0);
        check("s6_rst_pend", 8'(pendientes), 8'b00000);
        tick();
        rst_n = 1'b1;

        // ---- reset mid-travel ----
        tick();
        solicitud = 5'b10000;
        tick();
        solicitud = 5'b00000;
        tick();
        check("s7_sube", 8'(accion), 8'b10);
        #2 rst_n = 1'b0;
        #1;
        check("s7_motor", 8'(accion), 8'b00);
        check("s7_pend", 8'(pendientes), 8'b00000);
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
